// File: rtl/spi_sd_init_seq.sv
// SD card SPI-mode initialisation sequencer: CMD0, CMD8, CMD55/ACMD41 polling and,
// when SPI_SEQ_CMD58_EN is defined, a CMD58 OCR read that reports card capacity status.
module spi_sd_init_seq #(
  parameter int ACMD41_MAX = 255,
  parameter int GAP_CYCLES = 16
) (
  input  logic        spi_clk_i,
  input  logic        spi_rst_i,
  input  logic        seq_start_i,
  output logic        seq_busy_o,
  output logic        seq_ready_o,
  output logic        seq_error_o,
  output logic [2:0]  err_code_o,
  output logic        ccs_o,
  output logic        spi_start_o,
  output logic [47:0] transmission_data_o,
  output logic [1:0]  clock_divider_o,
  output logic        spi_sendenb_o,
  output logic        spi_fbo_o,
  input  logic        spi_done_i,
  input  logic [79:0] received_data_i
);

  localparam int CNT_W = (ACMD41_MAX < 2) ? 1 : $clog2(ACMD41_MAX + 1);
  localparam int GAP_W = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  localparam logic [47:0] FRAME_CMD0   = 48'h4000_0000_0095;
  localparam logic [47:0] FRAME_CMD8   = 48'h4800_0001_AA87;
  localparam logic [47:0] FRAME_CMD55  = 48'h7700_0000_0001;
  localparam logic [47:0] FRAME_ACMD41 = 48'h6940_0000_0001;
  localparam logic [47:0] FRAME_CMD58  = 48'h7A00_0000_0001;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_CMD0    = 3'd1;
  localparam logic [2:0] ERR_CMD8    = 3'd2;
  localparam logic [2:0] ERR_CMD55   = 3'd3;
  localparam logic [2:0] ERR_TIMEOUT = 3'd4;
  localparam logic [2:0] ERR_ACMD41  = 3'd5;
  localparam logic [2:0] ERR_CMD58   = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT, S_CHECK, S_GAP, S_READY, S_ERROR
  } state_e;

  typedef enum logic [2:0] {
    C_CMD0, C_CMD8, C_CMD55, C_ACMD41, C_CMD58
  } cmd_e;

  function automatic logic [47:0] frame_of(input cmd_e c);
    case (c)
      C_CMD0:   frame_of = FRAME_CMD0;
      C_CMD8:   frame_of = FRAME_CMD8;
      C_CMD55:  frame_of = FRAME_CMD55;
      C_ACMD41: frame_of = FRAME_ACMD41;
      C_CMD58:  frame_of = FRAME_CMD58;
      default:  frame_of = FRAME_CMD0;
    endcase
  endfunction

  state_e             state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic [CNT_W-1:0]   acmd_cnt_q, acmd_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               done_q;
  logic [7:0]         r1_q, r1_d;
  logic [31:0]        pay_q, pay_d;
  logic               busy_q, busy_d;
  logic               ready_q, ready_d;
  logic               error_q, error_d;
  logic [2:0]         err_code_q, err_code_d;
  logic               ccs_q, ccs_d;
  logic               start_q, start_d;
  logic [47:0]        tx_q, tx_d;
  logic [1:0]         div_q, div_d;
  logic               sendenb_q, sendenb_d;

  logic               done_rise;
  logic [2:0]         fail;
  logic               fin;
  cmd_e               adv;

  // Upper response bits and unneeded payload bits are deliberately ignored.
  logic unused_rx;
  assign unused_rx = ^{received_data_i[79:40], pay_q};

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    acmd_cnt_d = acmd_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    r1_d       = r1_q;
    pay_d      = pay_q;
    err_code_d = err_code_q;
    ccs_d      = ccs_q;
    tx_d       = tx_q;
    fail       = ERR_NONE;
    fin        = 1'b0;
    adv        = cmd_q;
    done_rise  = spi_done_i & ~done_q;

    unique case (state_q)
      S_IDLE, S_READY, S_ERROR: begin
        if (seq_start_i) begin
          state_d    = S_ISSUE;
          cmd_d      = C_CMD0;
          acmd_cnt_d = '0;
          err_code_d = ERR_NONE;
          ccs_d      = 1'b0;
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // Only a fresh 0->1 transition of done counts; a level left high is stale.
        if (done_rise) begin
          r1_d    = received_data_i[39:32];
          pay_d   = received_data_i[31:0];
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        case (cmd_q)
          C_CMD0: begin
            if (r1_q != 8'h01) fail = ERR_CMD0;
            else adv = C_CMD8;
          end
          C_CMD8: begin
            if (r1_q != 8'h01 || pay_q[11:0] != 12'h1AA) fail = ERR_CMD8;
            else adv = C_CMD55;
          end
          C_CMD55: begin
            if (r1_q[7:1] != 7'd0) fail = ERR_CMD55;
            else adv = C_ACMD41;
          end
          C_ACMD41: begin
            if (r1_q == 8'h00) begin
`ifdef SPI_SEQ_CMD58_EN
              adv = C_CMD58;
`else
              fin = 1'b1;
`endif
            end else if (r1_q == 8'h01) begin
              acmd_cnt_d = acmd_cnt_q + 1'b1;
              if (int'(acmd_cnt_q) + 1 >= ACMD41_MAX) fail = ERR_TIMEOUT;
              else adv = C_CMD55;
            end else begin
              fail = ERR_ACMD41;
            end
          end
`ifdef SPI_SEQ_CMD58_EN
          C_CMD58: begin
            if (r1_q != 8'h00) fail = ERR_CMD58;
            else begin
              fin   = 1'b1;
              ccs_d = pay_q[30];
            end
          end
`endif
          default: fin = 1'b1;
        endcase

        if (fail != ERR_NONE) begin
          state_d    = S_ERROR;
          err_code_d = fail;
        end else if (fin) begin
          state_d = S_READY;
        end else begin
          state_d   = S_GAP;
          cmd_d     = adv;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        // The engine must also have dropped done before the next command starts.
        if (int'(gap_cnt_q) + 1 < GAP_CYCLES) gap_cnt_d = gap_cnt_q + 1'b1;
        else if (!spi_done_i) state_d = S_ISSUE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d    = state_d inside {S_ISSUE, S_WAIT, S_CHECK, S_GAP};
    start_d   = state_d inside {S_ISSUE, S_WAIT};
    sendenb_d = busy_d;
    ready_d   = (state_d == S_READY);
    error_d   = (state_d == S_ERROR);
    div_d     = (state_d == S_READY) ? 2'b00 : 2'b11;
    if (state_d == S_ISSUE) tx_d = frame_of(cmd_d);
  end

  always_ff @(posedge spi_clk_i or negedge spi_rst_i) begin
    if (!spi_rst_i) begin
      state_q    <= S_IDLE;
      cmd_q      <= C_CMD0;
      acmd_cnt_q <= '0;
      gap_cnt_q  <= '0;
      done_q     <= 1'b0;
      r1_q       <= '0;
      pay_q      <= '0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= ERR_NONE;
      ccs_q      <= 1'b0;
      start_q    <= 1'b0;
      tx_q       <= '0;
      div_q      <= 2'b11;
      sendenb_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      acmd_cnt_q <= acmd_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      done_q     <= spi_done_i;
      r1_q       <= r1_d;
      pay_q      <= pay_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      ccs_q      <= ccs_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      div_q      <= div_d;
      sendenb_q  <= sendenb_d;
    end
  end

  assign seq_busy_o          = busy_q;
  assign seq_ready_o         = ready_q;
  assign seq_error_o         = error_q;
  assign err_code_o          = err_code_q;
  assign ccs_o               = ccs_q;
  assign spi_start_o         = start_q;
  assign transmission_data_o = tx_q;
  assign clock_divider_o     = div_q;
  assign spi_sendenb_o       = sendenb_q;
  assign spi_fbo_o           = 1'b0;

endmodule

// File: tb/tb_spi_sd_init_seq.sv
// Bench for spi_sd_init_seq: behavioural SPI engine, table-driven and random command
// scenarios scored against a sequential reference of the SD init flow.
`timescale 1ns/1ps
module tb_spi_sd_init_seq;
  localparam int ACMD41_MAX = 3;
  localparam int GAP_CYCLES = 4;
`ifdef SPI_SEQ_CMD58_EN
  localparam bit C58 = 1'b1;
`else
  localparam bit C58 = 1'b0;
`endif
  localparam logic [47:0] F0  = 48'h400000000095;
  localparam logic [47:0] F8  = 48'h48000001AA87;
  localparam logic [47:0] F55 = 48'h770000000001;
  localparam logic [47:0] F41 = 48'h694000000001;
  localparam logic [47:0] F58 = 48'h7A0000000001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        seq_start;
  logic        busy, ready, error, ccs, start, sendenb, fbo;
  logic [2:0]  code;
  logic [47:0] tx;
  logic [1:0]  div;
  logic        eng_en, eng_done, man_done;
  logic [79:0] eng_rx, man_rx;
  wire         done_w = eng_en ? eng_done : man_done;
  wire  [79:0] rx_w   = eng_en ? eng_rx : man_rx;

  always #5 clk = ~clk;

  spi_sd_init_seq #(.ACMD41_MAX(ACMD41_MAX), .GAP_CYCLES(GAP_CYCLES)) dut (
    .spi_clk_i(clk), .spi_rst_i(rst_n), .seq_start_i(seq_start),
    .seq_busy_o(busy), .seq_ready_o(ready), .seq_error_o(error),
    .err_code_o(code), .ccs_o(ccs), .spi_start_o(start),
    .transmission_data_o(tx), .clock_divider_o(div),
    .spi_sendenb_o(sendenb), .spi_fbo_o(fbo),
    .spi_done_i(done_w), .received_data_i(rx_w)
  );

  typedef struct {
    logic [7:0]  r1_0;
    logic [7:0]  r1_8;
    logic [31:0] pay8;
    logic [7:0]  r1_55;
    int          n_busy;
    logic [7:0]  r1_41;
    logic [7:0]  r1_58;
    logic [31:0] ocr;
    bit          exp_ready;
    logic [2:0]  exp_code;
    bit          exp_ccs;
    int          exp_frames;
  } vec_t;

  int          n_chk = 0, n_pass = 0;
  vec_t        cur;
  int          acmd_seen = 0;
  logic [47:0] log_q[$];
  logic [47:0] m_q[$];
  bit          m_ready, m_ccs;
  logic [2:0]  m_code;
  int          min_low = 1000;
  int          proto_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // SD init flow as a plain sequential program: which frames go out and how it ends.
  task automatic model(input vec_t v);
    logic [7:0] r;
    m_q.delete(); m_ready = 1'b0; m_code = 3'd0; m_ccs = 1'b0;
    m_q.push_back(F0);
    if (v.r1_0 != 8'h01) begin m_code = 3'd1; return; end
    m_q.push_back(F8);
    if (v.r1_8 != 8'h01 || v.pay8[11:0] != 12'h1AA) begin m_code = 3'd2; return; end
    for (int a = 0; a < ACMD41_MAX; a++) begin
      m_q.push_back(F55);
      if (v.r1_55 > 8'h01) begin m_code = 3'd3; return; end
      m_q.push_back(F41);
      r = (a < v.n_busy) ? 8'h01 : v.r1_41;
      if (r == 8'h00) begin
        if (C58) begin
          m_q.push_back(F58);
          if (v.r1_58 != 8'h00) begin m_code = 3'd6; return; end
          m_ccs = v.ocr[30];
        end
        m_ready = 1'b1;
        return;
      end
      if (r != 8'h01) begin m_code = 3'd5; return; end
    end
    m_code = 3'd4;
  endtask

  // Behavioural SPI engine: logs each frame, answers after a random latency,
  // and holds done for a random time.
  initial begin : engine
    int          st = 0;
    int          wait_n = 0;
    int          low_cnt = 0;
    logic        prev_start = 1'b0;
    logic        rise;
    logic [47:0] fr = '0;
    logic [7:0]  r1;
    logic [31:0] pl;
    eng_done = 1'b0;
    eng_rx   = '0;
    forever begin
      @(negedge clk);
      if (!eng_en) begin
        st = 0; eng_done = 1'b0; prev_start = start; low_cnt = 0;
      end else begin
        rise = start && !prev_start;
        if (rise) begin
          if (done_w) proto_err++;
          if (log_q.size() > 0 && low_cnt < min_low) min_low = low_cnt;
          low_cnt = 0;
        end
        if (!start) low_cnt++;
        case (st)
          0: if (rise) begin
            fr = tx; log_q.push_back(tx); wait_n = $urandom_range(1, 4); st = 1;
          end
          1: begin
            if (tx !== fr) proto_err++;
            wait_n--;
            if (wait_n == 0) begin
              pl = $urandom;
              case (fr[47:40])
                8'h40:   r1 = cur.r1_0;
                8'h48:   begin r1 = cur.r1_8; pl = cur.pay8; end
                8'h77:   r1 = cur.r1_55;
                8'h69:   begin r1 = (acmd_seen < cur.n_busy) ? 8'h01 : cur.r1_41; acmd_seen++; end
                8'h7A:   begin r1 = cur.r1_58; pl = cur.ocr; end
                default: r1 = 8'hFF;
              endcase
              eng_rx[79:48] = $urandom;
              eng_rx[47:40] = 8'($urandom);
              eng_rx[39:32] = r1;
              eng_rx[31:0]  = pl;
              eng_done = 1'b1;
              wait_n = $urandom_range(0, 6);
              st = 2;
            end
          end
          default: if (wait_n == 0) begin eng_done = 1'b0; st = 0; end else wait_n--;
        endcase
        prev_start = start;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    check({tag, "_outs"}, 64'({busy, ready, error, code, ccs, start, sendenb, fbo, div}),
          64'({1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b11}));
    check({tag, "_frame"}, 64'(tx), 64'd0);
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (start !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    check({tag, "_seen"}, 64'(start === 1'b1), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input bit pulse, input string tag);
    int cyc = 0;
    cur = v; acmd_seen = 0; log_q.delete();
    model(v);
    @(negedge clk); seq_start = 1'b1;
    @(negedge clk); seq_start = 1'b0;
    check({tag, "_begin"}, 64'({busy, start, sendenb, ready, error, code, ccs, div}),
          64'({1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2'b11}));
    check({tag, "_frame0"}, 64'(tx), 64'(F0));
    while (!(ready || error) && cyc < 2000) begin
      @(negedge clk); cyc++;
      if (pulse && cyc == 6 && busy) begin
        seq_start = 1'b1; @(negedge clk); seq_start = 1'b0; cyc++;
      end
    end
    check({tag, "_finished"}, 64'(cyc < 2000), 64'd1);
    repeat (10) @(negedge clk);
    check({tag, "_ready"}, 64'(ready), 64'(v.exp_ready));
    check({tag, "_error"}, 64'(error), 64'(!v.exp_ready));
    check({tag, "_code"}, 64'(code), 64'(v.exp_code));
    check({tag, "_ccs"}, 64'(ccs), 64'(v.exp_ccs));
    check({tag, "_quiet"}, 64'({busy, start, sendenb, fbo}), 64'd0);
    check({tag, "_div"}, 64'(div), v.exp_ready ? 64'd0 : 64'd3);
    check({tag, "_nframes"}, 64'(log_q.size()), 64'(v.exp_frames));
    for (int i = 0; i < m_q.size() && i < log_q.size(); i++)
      check($sformatf("%s_frame%0d", tag, i), 64'(log_q[i]), 64'(m_q[i]));
  endtask

  initial begin : main
    vec_t tbl[9];
    vec_t v;
    logic [31:0] t;

    tbl[0] = '{8'h01, 8'h01, 32'h000001AA, 8'h01, 1, 8'h00, 8'h00, 32'hC0FF8000, 1'b1, 3'd0, C58, 6 + int'(C58)};
    tbl[1] = '{8'hFF, 8'h01, 32'h000001AA, 8'h01, 0, 8'h00, 8'h00, 32'hC0FF8000, 1'b0, 3'd1, 1'b0, 1};
    tbl[2] = '{8'h01, 8'h01, 32'h000001AB, 8'h01, 0, 8'h00, 8'h00, 32'h0,        1'b0, 3'd2, 1'b0, 2};
    tbl[3] = '{8'h01, 8'h05, 32'h000001AA, 8'h01, 0, 8'h00, 8'h00, 32'h0,        1'b0, 3'd2, 1'b0, 2};
    tbl[4] = '{8'h01, 8'h01, 32'h000001AA, 8'h04, 0, 8'h00, 8'h00, 32'h0,        1'b0, 3'd3, 1'b0, 3};
    tbl[5] = '{8'h01, 8'h01, 32'h000001AA, 8'h01, 5, 8'h01, 8'h00, 32'h0,        1'b0, 3'd4, 1'b0, 8};
    tbl[6] = '{8'h01, 8'h01, 32'h000001AA, 8'h00, 0, 8'h05, 8'h00, 32'h0,        1'b0, 3'd5, 1'b0, 4};
    tbl[7] = '{8'h01, 8'h01, 32'h000001AA, 8'h01, 0, 8'h00, 8'h01, 32'hFFFFFFFF, !C58, C58 ? 3'd6 : 3'd0, 1'b0, 4 + int'(C58)};
    tbl[8] = '{8'h01, 8'h01, 32'h000001AA, 8'h01, 2, 8'h00, 8'h00, 32'h80FF8000, 1'b1, 3'd0, 1'b0, 8 + int'(C58)};

    rst_n = 1'b0; seq_start = 1'b0; eng_en = 1'b0; man_done = 1'b0; man_rx = '0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst_n = 1'b1;

    // done already high when WAIT is entered must not complete the transfer
    man_done = 1'b1;
    repeat (2) @(negedge clk);
    seq_start = 1'b1; @(negedge clk); seq_start = 1'b0;
    check("stale_done_issue", 64'({start, sendenb}), 64'b11);
    check("stale_done_frame", 64'(tx), 64'(F0));
    repeat (4) @(negedge clk);
    check("stale_done_waiting", 64'({busy, start}), 64'b11);
    man_done = 1'b0; @(negedge clk);
    man_rx = {40'h0, 8'h01, 32'h0}; man_done = 1'b1; @(negedge clk);
    check("edge_completes", 64'({busy, start}), 64'b10);
    man_done = 1'b0;
    wait_start("cmd8");
    check("cmd8_frame", 64'(tx), 64'(F8));

    // reset while CMD8 is outstanding
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst_mid");
    man_rx = {40'h0, 8'h01, 32'h000001AA}; man_done = 1'b1;
    @(negedge clk); man_done = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("no_resume", 64'({busy, start, ready, error}), 64'd0);
    seq_start = 1'b1; @(negedge clk); seq_start = 1'b0;
    check("restart_frame", 64'(tx), 64'(F0));
    check("restart_start", 64'(start), 64'd1);
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1;
    eng_en = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_vec(tbl[i], i == 0, $sformatf("tbl%0d", i));

    for (int k = 0; k < 16; k++) begin
      v.r1_0  = ($urandom_range(0, 9) < 8) ? 8'h01 : 8'($urandom);
      v.r1_8  = ($urandom_range(0, 9) < 8) ? 8'h01 : 8'($urandom);
      t = $urandom;
      v.pay8  = ($urandom_range(0, 9) < 8) ? {t[31:12], 12'h1AA} : t;
      v.r1_55 = ($urandom_range(0, 9) < 8) ? 8'h01 : 8'($urandom);
      v.n_busy = $urandom_range(0, 3);
      v.r1_41 = ($urandom_range(0, 9) < 8) ? 8'h00 : 8'($urandom);
      v.r1_58 = ($urandom_range(0, 9) < 8) ? 8'h00 : 8'($urandom);
      v.ocr   = $urandom;
      model(v);
      v.exp_ready = m_ready; v.exp_code = m_code; v.exp_ccs = m_ccs; v.exp_frames = m_q.size();
      run_vec(v, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", k));
    end

    check("min_gap", 64'(min_low), 64'(GAP_CYCLES + 1));
    check("engine_protocol", 64'(proto_err), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
